// File: rtl/vga_pkg.sv
// VGA timing package: default 640x480@60 constants and the phase enum.
// Shared by vga_axis_cnt and vga_timing_gen.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// Exposes the phase being entered so the top can register its decode.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output phase_t       o_phase_nxt,
  output logic         o_wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] C_LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] C_FP   = W'(ACTIVE);
  localparam logic [W-1:0] C_SYNC = W'(ACTIVE + FP);
  localparam logic [W-1:0] C_BP   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  phase_t       r_phase;
  phase_t       w_phase_nxt;
  logic         w_wrap;

  // Reset parks at the last position so the first step lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= C_LAST;
      r_phase <= PH_BP;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next count and phase; phase boundaries are tested on the new count.
  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    w_wrap      = 1'b0;
    if (i_inc) begin
      w_wrap      = (r_count == C_LAST);
      w_count_nxt = w_wrap ? '0 : r_count + 1'b1;
      unique case (r_phase)
        PH_ACTIVE: if (w_count_nxt == C_FP)   w_phase_nxt = PH_FP;
        PH_FP:     if (w_count_nxt == C_SYNC) w_phase_nxt = PH_SYNC;
        PH_SYNC:   if (w_count_nxt == C_BP)   w_phase_nxt = PH_BP;
        PH_BP:     if (w_wrap)                w_phase_nxt = PH_ACTIVE;
        default:   w_phase_nxt = PH_BP;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_phase_nxt = w_phase_nxt;
  assign o_wrap      = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: coordinates, syncs, de, frame_start.
// Optional 16-bit frame counter output under VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = vga_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  import vga_pkg::*;

  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_v_inc;
  phase_t w_h_ph;
  phase_t w_v_ph;
  logic   r_de;
  logic   r_hs;
  logic   r_vs;
  logic   r_fs;

  assign w_v_inc = pix_en & w_h_wrap;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (CNT_W)
  ) u_h (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (pix_en),
    .o_count     (pixel_x),
    .o_phase_nxt (w_h_ph),
    .o_wrap      (w_h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (CNT_W)
  ) u_v (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_v_inc),
    .o_count     (pixel_y),
    .o_phase_nxt (w_v_ph),
    .o_wrap      (w_v_wrap)
  );

  // Register decode of the entered phases so outputs align with counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de <= 1'b0;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_fs <= 1'b0;
    end else begin
      r_de <= (w_h_ph == PH_ACTIVE) && (w_v_ph == PH_ACTIVE);
      r_hs <= (w_h_ph == PH_SYNC) ? HS_POL : ~HS_POL;
      r_vs <= (w_v_ph == PH_SYNC) ? VS_POL : ~VS_POL;
      r_fs <= w_h_wrap & w_v_wrap;
    end
  end

  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign frame_start = r_fs;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count frames on the same edge that raises frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_h_wrap & w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 instance plus a small-timing
// instance (HS_POL=1) so vertical and full-frame behaviour fit in time.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
  localparam int SVA = 6, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  logic [10:0] d_x, d_y, s_x, s_y;
  logic d_de, d_hs, d_vs, d_fs;
  logic s_de, s_hs, s_vs, s_fs;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .pixel_x(d_x), .pixel_y(d_y), .de(d_de),
    .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(11)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .pixel_x(s_x), .pixel_y(s_y), .de(s_de),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  obs_t od, os, ed, es;
  assign od = {d_x, d_y, d_de, d_hs, d_vs, d_fs};
  assign os = {s_x, s_y, s_de, s_hs, s_vs, s_fs};

  obs_t qd[$];
  obs_t qs[$];
  int checks = 0;
  int failures = 0;
  int dx, dy, sx, sy, dfc, sfc;
  logic dfs, sfs;

  function automatic obs_t expect_of(
    int x, int y, logic fs,
    int ha, int hf, int hs, int va, int vf, int vs,
    logic hp, logic vp);
    obs_t o;
    o.x  = x[10:0];
    o.y  = y[10:0];
    o.de = (x < ha) && (y < va);
    o.hs = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
    o.vs = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
    o.fs = fs;
    return o;
  endfunction

  task automatic model_reset();
    dx = H_TOTAL - 1; dy = V_TOTAL - 1;
    sx = SHT - 1;     sy = SVT - 1;
    dfs = 1'b0; sfs = 1'b0;
    dfc = 0; sfc = 0;
    qd.delete(); qs.delete();
  endtask

  // Drive one clk with the given strobe and queue the expected outputs.
  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    dfs = 1'b0; sfs = 1'b0;
    if (en) begin
      dx = (dx == H_TOTAL - 1) ? 0 : dx + 1;
      if (dx == 0) dy = (dy == V_TOTAL - 1) ? 0 : dy + 1;
      dfs = (dx == 0 && dy == 0);
      if (dfs) dfc = (dfc + 1) % 65536;
      sx = (sx == SHT - 1) ? 0 : sx + 1;
      if (sx == 0) sy = (sy == SVT - 1) ? 0 : sy + 1;
      sfs = (sx == 0 && sy == 0);
      if (sfs) sfc = (sfc + 1) % 65536;
    end
    qd.push_back(expect_of(dx, dy, dfs, DEF_H_ACTIVE, DEF_H_FP,
      DEF_H_SYNC, DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, 1'b0, 1'b0));
    qs.push_back(expect_of(sx, sy, sfs, SHA, SHF, SHS,
      SVA, SVF, SVS, 1'b1, 1'b0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    ed = {11'd799, 11'd524, 1'b0, 1'b1, 1'b1, 1'b0};
    es = {11'd24, 11'd12, 1'b0, 1'b0, 1'b1, 1'b0};
    checks += 2;
    if (od !== ed) begin
      failures++;
      $display("FAIL reset_dflt got=%h want=%h", od, ed);
    end
    if (os !== es) begin
      failures++;
      $display("FAIL reset_small got=%h want=%h", os, es);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (d_fc !== 16'd0) begin
      failures++;
      $display("FAIL reset_fcnt got=%0d want=0", d_fc);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_first_strobe();
    step(1'b1);
    ed = qd.pop_front(); es = qs.pop_front();
    checks += 3;
    if (od !== {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL first_const got=%h want=%h", od,
        {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1});
    end
    if (od !== ed) begin
      failures++;
      $display("FAIL first_dflt got=%h want=%h", od, ed);
    end
    if (os !== es) begin
      failures++;
      $display("FAIL first_small got=%h want=%h", os, es);
    end
    step(1'b0);
    ed = qd.pop_front(); es = qs.pop_front();
    checks += 2;
    if (od !== ed) begin
      failures++;
      $display("FAIL fs_drop_dflt got=%h want=%h", od, ed);
    end
    if (os !== es) begin
      failures++;
      $display("FAIL fs_drop_small got=%h want=%h", os, es);
    end
  endtask

  // Continuous strobes across one full default line from (0,0).
  task automatic test_hsync();
    for (int i = 1; i < H_TOTAL; i++) begin
      step(1'b1);
      ed = qd.pop_front(); es = qs.pop_front();
      checks += 2;
      if (od !== ed) begin
        failures++;
        $display("FAIL hline_dflt i=%0d got=%h want=%h", i, od, ed);
      end
      if (os !== es) begin
        failures++;
        $display("FAIL hline_small i=%0d got=%h want=%h", i, os, es);
      end
      if (i == 656 || i == 752 || i == 640) begin
        checks++;
        if (d_hs !== (i == 656 ? 1'b0 : 1'b1) || d_de !== 1'b0) begin
          failures++;
          $display("FAIL hsync_edge x=%0d hs=%b de=%b", i, d_hs, d_de);
        end
      end
      if (i == 655 || i == 751) begin
        checks++;
        if (d_hs !== (i == 655 ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL hsync_pre x=%0d hs=%b", i, d_hs);
        end
      end
    end
  endtask

  // Small instance over two frames: vsync on exactly V_SYNC lines.
  task automatic test_vertical();
    int vs_cnt;
    for (int f = 0; f < 2; f++) begin
      vs_cnt = 0;
      for (int i = 0; i < SHT * SVT; i++) begin
        step(1'b1);
        ed = qd.pop_front(); es = qs.pop_front();
        checks += 2;
        if (od !== ed) begin
          failures++;
          $display("FAIL vert_dflt i=%0d got=%h want=%h", i, od, ed);
        end
        if (os !== es) begin
          failures++;
          $display("FAIL vert_small i=%0d got=%h want=%h", i, os, es);
        end
        if (s_vs === 1'b0) vs_cnt++;
      end
      checks++;
      if (vs_cnt != SVS * SHT) begin
        failures++;
        $display("FAIL vsync_width got=%0d want=%0d", vs_cnt, SVS * SHT);
      end
    end
  endtask

  // Strobe every 4th clk; holds and 1-clk frame_start via scoreboard.
  task automatic test_strobe4();
    for (int i = 0; i < 4 * 400; i++) begin
      step((i % 4) == 0);
      ed = qd.pop_front(); es = qs.pop_front();
      checks += 2;
      if (od !== ed) begin
        failures++;
        $display("FAIL strobe4_dflt i=%0d got=%h want=%h", i, od, ed);
      end
      if (os !== es) begin
        failures++;
        $display("FAIL strobe4_small i=%0d got=%h want=%h", i, os, es);
      end
    end
  endtask

  // Reset, land on (0,0), then one full small frame back to (0,0).
  task automatic test_frame();
    int fs_cnt;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1);
    void'(qd.pop_front());
    void'(qs.pop_front());
    fs_cnt = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      step(1'b1);
      es = qs.pop_front(); ed = qd.pop_front();
      checks++;
      if (os !== es) begin
        failures++;
        $display("FAIL frame_small i=%0d got=%h want=%h", i, os, es);
      end
      if (s_fs === 1'b1) fs_cnt++;
    end
    checks += 2;
    if (fs_cnt != 1) begin
      failures++;
      $display("FAIL frame_fs_count got=%0d want=1", fs_cnt);
    end
    if (os !== {11'd0, 11'd0, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL frame_end got=%h", os);
    end
`ifdef VGA_FRAME_CNT_EN
    checks += 2;
    if (s_fc !== 16'd2 || s_fc !== 16'(sfc)) begin
      failures++;
      $display("FAIL frame_cnt got=%0d want=2", s_fc);
    end
    if (d_fc !== 16'(dfc)) begin
      failures++;
      $display("FAIL frame_cnt_dflt got=%0d want=%0d", d_fc, dfc);
    end
`endif
  endtask

  // Async reset mid-line: outputs drop before any clk edge.
  task automatic test_reset_mid();
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      void'(qd.pop_front());
      void'(qs.pop_front());
    end
    rst = 1'b1;
    #1;
    checks += 2;
    if (od !== {11'd799, 11'd524, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_dflt got=%h", od);
    end
    if (os !== {11'd24, 11'd12, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid_small got=%h", os);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1);
    ed = qd.pop_front(); es = qs.pop_front();
    checks += 2;
    if (od !== ed || od.x !== 11'd0 || od.y !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_restart got=%h want=%h", od, ed);
    end
    if (os !== es) begin
      failures++;
      $display("FAIL rst_mid_small_restart got=%h want=%h", os, es);
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_first_strobe();
    test_hsync();
    test_vertical();
    test_strobe4();
    test_frame();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
